// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
//   Shared definitions for the IR line-sensor scan controller:
//     - legacy state codes and the scan FSM state type
//     - reduced timer widths used when FAST_SIM is set
//     - helpers to pick timer widths and to find the next enabled channel
// ---------------------------------------------------------------------------
package ir_pkg;

   localparam int unsigned MAX_CH        = 8;
   localparam int unsigned FAST_PERIOD_W = 14;
   localparam int unsigned FAST_SETTLE_W = 11;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_TMR  = 3'd1;
   localparam logic [2:0] ST_SETTLE    = 3'd2;
   localparam logic [2:0] ST_START_CNV = 3'd3;
   localparam logic [2:0] ST_WAIT_CNV  = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      WAIT_TMR  = ST_WAIT_TMR,
      SETTLE    = ST_SETTLE,
      START_CNV = ST_START_CNV,
      WAIT_CNV  = ST_WAIT_CNV,
      DONE      = ST_DONE
   } ir_state_t;

   function automatic int unsigned pick_w(input int unsigned fast_sim,
                                          input int unsigned norm_w,
                                          input int unsigned fast_w);
      return (fast_sim != 0) ? fast_w : norm_w;
   endfunction

   // Lowest enabled channel at or above 'from'. Bit 3 set means none remains.
   function automatic logic [3:0] next_ch(input logic [MAX_CH-1:0] mask,
                                          input logic [3:0]        from);
      logic [3:0] r;
      r = 4'b1000;
      for (int unsigned i = MAX_CH; i > 0; i--) begin
         if (mask[i-1] && (4'(i-1) >= from)) r = 4'(i-1);
      end
      return r;
   endfunction

endpackage

// File: rtl/A2D_intf.sv
// ---------------------------------------------------------------------------
// A2D_intf
//   SPI master for the external A2D converter. One conversion is one SS_n
//   frame of RES_W+4 bits, SCLK = clk/8, mode 0 (MOSI changes on SCLK fall,
//   MISO sampled on SCLK rise). The first 4 bits carry {1'b0, chnnl}, the
//   remaining RES_W bits return the sample MSB first.
//
//   clk, rst_n   : clock, asynchronous active-low reset
//   strt_cnv     : one-cycle start request (ignored while a frame runs)
//   chnnl        : channel to convert, captured at strt_cnv
//   cnv_cmplt    : one-cycle pulse when res is valid
//   res          : converted sample
//   SS_n/SCLK/MOSI/MISO : SPI pins
// ---------------------------------------------------------------------------
module A2D_intf #(
   parameter int unsigned RES_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             strt_cnv,
   input  logic [2:0]       chnnl,
   output logic             cnv_cmplt,
   output logic [RES_W-1:0] res,
   output logic             SS_n,
   output logic             SCLK,
   output logic             MOSI,
   input  logic             MISO
);

   localparam int unsigned FRAME_W = RES_W + 4;
   localparam int unsigned BIT_CW  = $clog2(FRAME_W);

   logic [2:0]         div;
   logic [BIT_CW-1:0]  bit_cnt;
   logic [FRAME_W-1:0] tx;
   logic [RES_W-1:0]   rx;
   logic               last_bit;

   assign last_bit = (bit_cnt == BIT_CW'(FRAME_W-1)) && (div == 3'd7);
   assign SCLK     = div[2];
   assign MOSI     = tx[FRAME_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SS_n      <= 1'b1;
         div       <= '0;
         bit_cnt   <= '0;
         tx        <= '0;
         rx        <= '0;
         cnv_cmplt <= 1'b0;
         res       <= '0;
      end else begin
         cnv_cmplt <= 1'b0;
         if (SS_n) begin
            if (strt_cnv) begin
               SS_n    <= 1'b0;
               div     <= '0;
               bit_cnt <= '0;
               tx      <= {1'b0, chnnl, {RES_W{1'b0}}};
            end
         end else begin
            div <= div + 3'd1;
            // The command bits also shift through rx; only the last RES_W
            // bits of the frame survive.
            if (div == 3'd3) rx <= {rx[RES_W-2:0], MISO};
            if (div == 3'd7) begin
               tx      <= {tx[FRAME_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
            end
            if (last_bit) begin
               SS_n      <= 1'b1;
               cnv_cmplt <= 1'b1;
               res       <= rx;
            end
         end
      end
   end

endmodule

// File: rtl/ir_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ir_scan_ctrl
//   IR line-sensor scan controller. Enables the IR emitter, waits for it to
//   settle, converts every enabled channel through the A2D, then publishes
//   the samples, the scan maximum and a hysteretic line-present flag.
//
//   clk, rst_n    : clock, asynchronous active-low reset
//   mode_cont     : 1 = free-running scans paced by the period timer
//   trig          : single-shot start pulse (ignored while busy)
//   ch_mask       : per-channel enable, sampled when settling ends
//   thr_hi/thr_lo : line set / clear thresholds
//   IR_en         : emitter enable
//   busy          : scan in progress
//   IR_vld        : one-cycle scan-complete pulse
//   IR_data       : samples, channel k at [k*RES_W +: RES_W]
//   max_val/max_idx : largest sample of the scan and its channel
//   line_present  : hysteretic line flag
//   SS_n/SCLK/MOSI/MISO : A2D SPI pins
// ---------------------------------------------------------------------------
module ir_scan_ctrl
   import ir_pkg::*;
#(
   parameter int unsigned NUM_CH   = 8,
   parameter int unsigned RES_W    = 12,
   parameter int unsigned PERIOD_W = 18,
   parameter int unsigned SETTLE_W = 12,
   parameter int unsigned FAST_SIM = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode_cont,
   input  logic                    trig,
   input  logic [NUM_CH-1:0]       ch_mask,
   input  logic [RES_W-1:0]        thr_hi,
   input  logic [RES_W-1:0]        thr_lo,
   output logic                    IR_en,
   output logic                    busy,
   output logic                    IR_vld,
   output logic [NUM_CH*RES_W-1:0] IR_data,
   output logic [RES_W-1:0]        max_val,
   output logic [2:0]              max_idx,
   output logic                    line_present,
   output logic                    SS_n,
   output logic                    SCLK,
   output logic                    MOSI,
   input  logic                    MISO
);

   localparam int unsigned PW = pick_w(FAST_SIM, PERIOD_W, FAST_PERIOD_W);
   localparam int unsigned SW = pick_w(FAST_SIM, SETTLE_W, FAST_SETTLE_W);
   localparam int unsigned TW = (PW > SW) ? PW : SW;

   ir_state_t         state;
   logic [TW-1:0]     timer;
   logic [2:0]        ch_ptr;
   logic [MAX_CH-1:0] mask_now;
   logic [MAX_CH-1:0] mask_q;
   logic [RES_W-1:0]  run_max;
   logic [2:0]        run_idx;
   logic              strt_cnv;
   logic              cnv_cmplt;
   logic [RES_W-1:0]  res;
   logic              period_done;
   logic              settle_done;
   logic [3:0]        first_ch;
   logic [3:0]        later_ch;

   always_comb begin
      mask_now             = '0;
      mask_now[NUM_CH-1:0] = ch_mask;
   end

   // One timer serves both waits; each wait looks only at its own width.
   assign period_done = &timer[PW-1:0];
   assign settle_done = &timer[SW-1:0];
   assign first_ch    = next_ch(mask_now, 4'd0);
   assign later_ch    = next_ch(mask_q, {1'b0, ch_ptr} + 4'd1);
   assign strt_cnv    = (state == START_CNV);
   assign IR_en       = state inside {SETTLE, START_CNV, WAIT_CNV};
   assign busy        = !(state inside {IDLE, WAIT_TMR});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         timer        <= '0;
         ch_ptr       <= '0;
         mask_q       <= '0;
         run_max      <= '0;
         run_idx      <= '0;
         IR_data      <= '0;
         max_val      <= '0;
         max_idx      <= '0;
         line_present <= 1'b0;
         IR_vld       <= 1'b0;
      end else begin
         IR_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (mode_cont) begin
                  state <= WAIT_TMR;
                  timer <= '0;
               end else if (trig) begin
                  state <= SETTLE;
                  timer <= '0;
               end
            end
            WAIT_TMR: begin
               if (period_done) begin
                  state <= SETTLE;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            SETTLE: begin
               if (settle_done) begin
                  timer   <= '0;
                  mask_q  <= mask_now;
                  run_max <= '0;
                  run_idx <= '0;
                  if (first_ch[3]) begin
                     state <= DONE;
                  end else begin
                     ch_ptr <= first_ch[2:0];
                     state  <= START_CNV;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            START_CNV: state <= WAIT_CNV;
            WAIT_CNV: begin
               if (cnv_cmplt) begin
                  for (int unsigned k = 0; k < NUM_CH; k++) begin
                     if (ch_ptr == 3'(k)) IR_data[k*RES_W +: RES_W] <= res;
                  end
                  // Strict compare: the lowest channel keeps a tie.
                  if (res > run_max) begin
                     run_max <= res;
                     run_idx <= ch_ptr;
                  end
                  if (later_ch[3]) begin
                     state <= DONE;
                  end else begin
                     ch_ptr <= later_ch[2:0];
                     state  <= START_CNV;
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               IR_vld  <= 1'b1;
               max_val <= run_max;
               max_idx <= run_idx;
               if (run_max > thr_hi)      line_present <= 1'b1;
               else if (run_max < thr_lo) line_present <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   A2D_intf #(
      .RES_W(RES_W)
   ) u_a2d (
      .clk      (clk),
      .rst_n    (rst_n),
      .strt_cnv (strt_cnv),
      .chnnl    (ch_ptr),
      .cnv_cmplt(cnv_cmplt),
      .res      (res),
      .SS_n     (SS_n),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );

endmodule

// File: tb/tb_ir_scan_ctrl.sv
module tb_ir_scan_ctrl;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        mode_cont = 1'b0;
   logic        trig      = 1'b0;
   logic [7:0]  ch_mask   = 8'hFF;
   logic [11:0] thr_hi    = 12'h040;
   logic [11:0] thr_lo    = 12'h020;
   logic        IR_en, busy, IR_vld, line_present, SS_n, SCLK, MOSI;
   logic        MISO      = 1'b0;
   logic [95:0] IR_data;
   logic [11:0] max_val;
   logic [2:0]  max_idx;

   int          vec    = 0;
   int          miscmp = 0;

   // ADC contents and reference model state
   logic [11:0] adc_val  [8];
   logic [11:0] exp_data [8];
   logic [11:0] exp_max  = '0;
   logic [2:0]  exp_idx  = '0;
   logic        exp_lp   = 1'b0;
   int          exp_ch   [$];

   // SPI slave observation
   int          conv_q   [$];
   int          frames   = 0;
   int          vld_cnt  = 0;
   int          sbit     = 0;
   logic [3:0]  cmd      = '0;
   logic [11:0] sval     = '0;

   always #5 clk = ~clk;

   ir_scan_ctrl #(
      .NUM_CH  (8),
      .RES_W   (12),
      .PERIOD_W(18),
      .SETTLE_W(12),
      .FAST_SIM(1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode_cont   (mode_cont),
      .trig        (trig),
      .ch_mask     (ch_mask),
      .thr_hi      (thr_hi),
      .thr_lo      (thr_lo),
      .IR_en       (IR_en),
      .busy        (busy),
      .IR_vld      (IR_vld),
      .IR_data     (IR_data),
      .max_val     (max_val),
      .max_idx     (max_idx),
      .line_present(line_present),
      .SS_n        (SS_n),
      .SCLK        (SCLK),
      .MOSI        (MOSI),
      .MISO        (MISO)
   );

   // A2D slave: 4 command bits {0,ch} then 12 data bits, mode 0.
   always @(negedge SS_n or posedge SCLK) begin
      if (SCLK !== 1'b1) begin
         sbit = 0;
         frames++;
      end else if (SS_n === 1'b0) begin
         if (sbit < 4) cmd = {cmd[2:0], MOSI};
         sbit++;
      end
   end

   always @(negedge SCLK) begin
      if (SS_n === 1'b0) begin
         if (sbit == 4) begin
            sval = adc_val[cmd[2:0]];
            conv_q.push_back(int'(cmd[2:0]));
         end
         if (sbit >= 4 && sbit < 16) MISO = sval[15-sbit];
      end
   end

   always @(negedge clk) if (IR_vld === 1'b1) vld_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vec++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
   endtask

   function automatic logic [95:0] exp_packed();
      logic [95:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[k*12 +: 12] = exp_data[k];
      return r;
   endfunction

   // Scan outcome from the rules: enabled channels in ascending order are
   // converted, maximum over them, lowest channel among equal maxima.
   task automatic model_scan(input logic [7:0] m);
      exp_ch.delete();
      exp_max = '0;
      exp_idx = '0;
      for (int k = 0; k < 8; k++) begin
         if (m[k]) begin
            exp_ch.push_back(k);
            exp_data[k] = adc_val[k];
            if (adc_val[k] > exp_max) exp_max = adc_val[k];
         end
      end
      if (exp_max != 0) begin
         for (int k = 7; k >= 0; k--)
            if (m[k] && adc_val[k] == exp_max) exp_idx = 3'(k);
      end
      if (exp_max > thr_hi)      exp_lp = 1'b1;
      else if (exp_max < thr_lo) exp_lp = 1'b0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) exp_data[k] = '0;
      exp_lp = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".IR_data"}, IR_data, 96'd0);
      check({tag, ".max_val"}, 96'(max_val), 96'd0);
      check({tag, ".max_idx"}, 96'(max_idx), 96'd0);
      check({tag, ".line"}, 96'(line_present), 96'd0);
      check({tag, ".IR_vld"}, 96'(IR_vld), 96'd0);
      check({tag, ".IR_en"}, 96'(IR_en), 96'd0);
      check({tag, ".busy"}, 96'(busy), 96'd0);
      check({tag, ".SS_n"}, 96'(SS_n), 96'd1);
   endtask

   // Wait for IR_vld; count cycles where busy fell after the scan began.
   task automatic wait_scan(input int budget, output int drops);
      int  n       = 0;
      bit  started = 1'b0;
      drops = 0;
      while (IR_vld !== 1'b1) begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) started = 1'b1;
         else if (started && IR_vld !== 1'b1) drops++;
         if (n > budget) begin
            check("scan_timeout", 96'(IR_vld), 96'd1);
            break;
         end
      end
   endtask

   task automatic check_scan(input string tag, input int base, input int v0);
      logic [95:0] o_obs = '0;
      logic [95:0] o_exp = '0;
      check({tag, ".data"}, IR_data, exp_packed());
      check({tag, ".max_val"}, 96'(max_val), 96'(exp_max));
      check({tag, ".max_idx"}, 96'(max_idx), 96'(exp_idx));
      check({tag, ".line"}, 96'(line_present), 96'(exp_lp));
      for (int i = base; i < conv_q.size(); i++) o_obs = (o_obs << 4) | 96'(conv_q[i]);
      foreach (exp_ch[i]) o_exp = (o_exp << 4) | 96'(exp_ch[i]);
      check({tag, ".nconv"}, 96'(conv_q.size() - base), 96'(exp_ch.size()));
      check({tag, ".order"}, o_obs, o_exp);
      tick(1);
      check({tag, ".vld_pulse"}, 96'(IR_vld), 96'd0);
      tick(3);
      check({tag, ".vld_count"}, 96'(vld_cnt - v0), 96'd1);
      check({tag, ".idle_busy"}, 96'(busy), 96'd0);
      check({tag, ".idle_IR_en"}, 96'(IR_en), 96'd0);
   endtask

   // kind 0: plain; 1: change ch_mask once converting; 2: second trig while busy
   task automatic do_single(input string tag, input logic [7:0] m, input int kind,
                            input logic [7:0] mid_mask);
      int base;
      int v0;
      int drops;
      int n;
      ch_mask = m;
      model_scan(m);
      base = conv_q.size();
      v0   = vld_cnt;
      pulse_trig();
      if (kind == 2) begin
         tick(20);
         pulse_trig();
      end
      if (kind == 1) begin
         n = 0;
         while (SS_n !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
         end
         check({tag, ".frame_start"}, 96'(SS_n), 96'd0);
         ch_mask = mid_mask;
      end
      wait_scan(8000, drops);
      check_scan(tag, base, v0);
   endtask

   initial begin
      int drops;
      int n;
      int base;
      int v0;
      int f0;

      for (int k = 0; k < 8; k++) adc_val[k] = 12'(k * 12'h100);
      adc_val[0] = 12'h005;
      model_reset();

      // reset values
      tick(3);
      check_reset("reset");
      rst_n = 1'b1;
      tick(2);

      // continuous scan, full mask; drop mode_cont once the scan is running
      thr_hi    = 12'h040;
      thr_lo    = 12'h020;
      ch_mask   = 8'hFF;
      mode_cont = 1'b1;
      model_scan(8'hFF);
      base = conv_q.size();
      v0   = vld_cnt;
      n    = 0;
      while (busy !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("cont.start", 96'(busy), 96'd1);
      check("cont.IR_en_settle", 96'(IR_en), 96'd1);
      mode_cont = 1'b0;
      wait_scan(8000, drops);
      check("cont.busy_drops", 96'(drops), 96'd0);
      check("cont.max_const", 96'(max_val), 96'h700);
      check("cont.idx_const", 96'(max_idx), 96'd7);
      check_scan("cont", base, v0);

      // sparse mask, ch_mask changed mid-scan must not matter
      for (int k = 0; k < 8; k++) adc_val[k] = 12'(12'h0A0 + k * 12'h011);
      do_single("mask24", 8'b0010_0100, 1, 8'hFF);
      check("mask24.idx_const", 96'(max_idx), 96'd5);

      // hysteresis: maxima 0x350, 0x200, 0x0F0 -> 1, 1, 0
      thr_hi = 12'h300;
      thr_lo = 12'h100;
      adc_val[3] = 12'h350;
      do_single("hyst0", 8'h08, 0, 8'h00);
      adc_val[3] = 12'h200;
      do_single("hyst1", 8'h08, 0, 8'h00);
      adc_val[3] = 12'h0F0;
      do_single("hyst2", 8'h08, 0, 8'h00);
      check("hyst2.line_const", 96'(line_present), 96'd0);

      // single shot with a second trig while busy
      do_single("dtrig", 8'hFF, 2, 8'h00);

      // tie between ch1 and ch4
      thr_hi = 12'h200;
      adc_val[1] = 12'h222;
      adc_val[4] = 12'h222;
      adc_val[6] = 12'h100;
      do_single("tie", 8'h52, 0, 8'h00);
      check("tie.idx_const", 96'(max_idx), 96'd1);

      // empty mask
      do_single("empty", 8'h00, 0, 8'h00);

      // reset while a conversion is in flight
      ch_mask = 8'hFF;
      f0 = frames;
      pulse_trig();
      n = 0;
      while (frames < f0 + 3 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check("rstcnv.reached", 96'(frames - f0), 96'd3);
      tick(40);
      #2 rst_n = 1'b0;
      #1 check_reset("rstcnv");
      model_reset();
      tick(2);
      rst_n = 1'b1;
      tick(2);
      for (int k = 0; k < 8; k++) adc_val[k] = 12'(12'h311 - k * 12'h021);
      do_single("rst_restart", 8'hFF, 0, 8'h00);

      // randomized scans
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 8; k++) adc_val[k] = 12'($urandom_range(1, 4095));
         thr_hi = 12'($urandom_range(1024, 4095));
         thr_lo = 12'($urandom_range(0, 1023));
         do_single($sformatf("rand%0d", r), 8'($urandom_range(1, 255)), 0, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
